// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX pipeline register with operand forwarding.
// Captures decoded operands and control each cycle. It drives the ALU
// operands from the register values, or from the EX/MEM or MEM/WB results
// when a younger result has not yet reached the register file.
module ex_operand_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int REG_ADDR      = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     flush,
    input  logic                     id_valid,
    input  logic [DATA_WIDTH-1:0]    id_rs1_data,
    input  logic [DATA_WIDTH-1:0]    id_rs2_data,
    input  logic [DATA_WIDTH-1:0]    id_imm,
    input  logic [REG_ADDR-1:0]      id_rs1,
    input  logic [REG_ADDR-1:0]      id_rs2,
    input  logic [REG_ADDR-1:0]      id_rd,
    input  logic                     id_alu_src,
    input  logic [OPCODE_LENGTH-1:0] id_alu_op,
    input  logic                     id_reg_write,
    input  logic                     exmem_reg_write,
    input  logic [REG_ADDR-1:0]      exmem_rd,
    input  logic [DATA_WIDTH-1:0]    exmem_result,
    input  logic                     memwb_reg_write,
    input  logic [REG_ADDR-1:0]      memwb_rd,
    input  logic [DATA_WIDTH-1:0]    memwb_result,
    output logic                     ex_valid,
    output logic [REG_ADDR-1:0]      ex_rd,
    output logic                     ex_reg_write,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [DATA_WIDTH-1:0]    ex_store_data,
    output logic [1:0]               fwd_a,
    output logic [1:0]               fwd_b
);

    // Forwarding source encodings, also exported on fwd_a/fwd_b.
    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    typedef struct packed {
        logic                     valid;
        logic [DATA_WIDTH-1:0]    rs1_data;
        logic [DATA_WIDTH-1:0]    rs2_data;
        logic [DATA_WIDTH-1:0]    imm;
        logic [REG_ADDR-1:0]      rs1;
        logic [REG_ADDR-1:0]      rs2;
        logic [REG_ADDR-1:0]      rd;
        logic                     alu_src;
        logic [OPCODE_LENGTH-1:0] alu_op;
        logic                     reg_write;
    } stage_t;

    stage_t stage_q;
    stage_t stage_d;

    logic [1:0]            fwd_a_s;
    logic [1:0]            fwd_b_s;
    logic [DATA_WIDTH-1:0] fwd_rs1_s;
    logic [DATA_WIDTH-1:0] fwd_rs2_s;

    // Choose the forwarding source for one source register. EX/MEM wins
    // because it holds the newer value. x0 is hard-wired, so it never forwards.
    function automatic logic [1:0] fwd_select(
        input logic [REG_ADDR-1:0] rs,
        input logic                exmem_we,
        input logic [REG_ADDR-1:0] exmem_dst,
        input logic                memwb_we,
        input logic [REG_ADDR-1:0] memwb_dst
    );
        logic [1:0] sel;
        sel = FWD_REG;
        if (exmem_we && (exmem_dst != {REG_ADDR{1'b0}}) && (exmem_dst == rs)) begin
            sel = FWD_EXMEM;
        end else if (memwb_we && (memwb_dst != {REG_ADDR{1'b0}}) && (memwb_dst == rs)) begin
            sel = FWD_MEMWB;
        end else begin
            sel = FWD_REG;
        end
        return sel;
    endfunction

    // Next stage contents: flush beats stall, and stall beats a normal load.
    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            stage_d = '0;
        end else if (stall) begin
            stage_d = stage_q;
        end else begin
            stage_d.valid     = id_valid;
            stage_d.rs1_data  = id_rs1_data;
            stage_d.rs2_data  = id_rs2_data;
            stage_d.imm       = id_imm;
            stage_d.rs1       = id_rs1;
            stage_d.rs2       = id_rs2;
            stage_d.rd        = id_rd;
            stage_d.alu_src   = id_alu_src;
            stage_d.alu_op    = id_alu_op;
            // An empty decode slot must not write back.
            stage_d.reg_write = id_valid & id_reg_write;
        end
    end

    // Stage register with synchronous reset. Reset also wins over stall and flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    // Forwarding select and operand muxes. This logic is not gated by valid
    // and stays live while the stage is stalled.
    always_comb begin
        fwd_a_s   = fwd_select(stage_q.rs1, exmem_reg_write, exmem_rd,
                               memwb_reg_write, memwb_rd);
        fwd_b_s   = fwd_select(stage_q.rs2, exmem_reg_write, exmem_rd,
                               memwb_reg_write, memwb_rd);
        fwd_rs1_s = stage_q.rs1_data;
        fwd_rs2_s = stage_q.rs2_data;
        case (fwd_a_s)
            FWD_EXMEM: fwd_rs1_s = exmem_result;
            FWD_MEMWB: fwd_rs1_s = memwb_result;
            default:   fwd_rs1_s = stage_q.rs1_data;
        endcase
        case (fwd_b_s)
            FWD_EXMEM: fwd_rs2_s = exmem_result;
            FWD_MEMWB: fwd_rs2_s = memwb_result;
            default:   fwd_rs2_s = stage_q.rs2_data;
        endcase
    end

    assign ex_valid      = stage_q.valid;
    assign ex_rd         = stage_q.rd;
    assign ex_reg_write  = stage_q.reg_write;
    assign Operation     = stage_q.alu_op;
    assign SrcA          = fwd_rs1_s;
    assign SrcB          = stage_q.alu_src ? stage_q.imm : fwd_rs2_s;
    assign ex_store_data = fwd_rs2_s;
    assign fwd_a         = fwd_a_s;
    assign fwd_b         = fwd_b_s;

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX pipeline register plus operand-forwarding selection, sitting directly upstream of the ALU. Each cycle it captures decoded operands and control from the decode stage, then drives the ALU's `SrcA`, `SrcB` and `Operation` inputs for the following cycle. Operands are forwarded from the EX/MEM or MEM/WB stages when a younger result has not yet reached the register file. Stall and flush inputs let the hazard unit hold the stage or insert a bubble.

## Interface
- `DATA_WIDTH`, 32, operand/result width
- `OPCODE_LENGTH`, 4, ALU operation code width
- `REG_ADDR`, 5, register index width
- `clk` in 1: the single clock; all state updates on the rising edge
- `reset` in 1: reset is synchronous and active-high
- `stall` in 1: hold all stage registers
- `flush` in 1: load a bubble
- `id_valid` in 1: decode slot holds a real instruction
- `id_rs1_data`, `id_rs2_data`, `id_imm` in DATA_WIDTH: register-file reads and the immediate
- `id_rs1`, `id_rs2`, `id_rd` in REG_ADDR: source and destination indices
- `id_alu_src` in 1: 1 selects the immediate for SrcB
- `id_alu_op` in OPCODE_LENGTH: ALU operation code
- `id_reg_write` in 1: instruction writes rd
- `exmem_reg_write` in 1, `exmem_rd` in REG_ADDR, `exmem_result` in DATA_WIDTH: EX/MEM writeback candidate
- `memwb_reg_write` in 1, `memwb_rd` in REG_ADDR, `memwb_result` in DATA_WIDTH: MEM/WB writeback candidate
- `ex_valid` out 1, `ex_rd` out REG_ADDR, `ex_reg_write` out 1: registered, passed downstream
- `Operation` out OPCODE_LENGTH: registered ALU code
- `SrcA`, `SrcB` out DATA_WIDTH: ALU operands, after forwarding
- `ex_store_data` out DATA_WIDTH: forwarded rs2 value, for stores
- `fwd_a`, `fwd_b` out 2: forwarding selection, for debug and coverage
  - 00 = register value
  - 10 = EX/MEM
  - 01 = MEM/WB

## Operation
- Stage registers hold: valid, rs1_data, rs2_data, imm, rs1, rs2, rd, alu_src, alu_op, reg_write.
- Update priority on each rising edge:
  - reset: all fields 0.
  - flush: bubble, i.e. all fields 0. Flush overrides stall.
  - stall: all fields unchanged.
  - otherwise: load the `id_*` inputs. If `id_valid`=0, valid and reg_write load 0; other fields load as presented.
- Forwarding for A is combinational and uses the registered rs1:
  - If `exmem_reg_write` && `exmem_rd`!=0 && `exmem_rd`==rs1: select `exmem_result`, `fwd_a`=10.
  - Else if `memwb_reg_write` && `memwb_rd`!=0 && `memwb_rd`==rs1: select `memwb_result`, `fwd_a`=01.
  - Else select the registered rs1_data, `fwd_a`=00.
- Forwarding for B uses the same rules on the registered rs2 and produces fwd_rs2 and `fwd_b`.
- EX/MEM has priority over MEM/WB because it holds the newer value.
- Register x0 is never forwarded, so rs=0 yields the registered data.
- Operand outputs:
  - `SrcA` = forwarded A.
  - `SrcB` = alu_src ? imm : fwd_rs2.
  - `ex_store_data` = fwd_rs2, independent of alu_src.
- `fwd_b` reflects the rs2 match even when alu_src=1.
- Forwarding does not depend on valid: a bubble simply carries reg_write=0 downstream.
- During stall, forwarding stays live, so `SrcA`/`SrcB` can change as EX/MEM and MEM/WB advance.

## Timing
- Latency: `id_*` to `ex_*`/`Operation` is 1 cycle.
- Forwarding inputs reach `SrcA`/`SrcB`/`ex_store_data`/`fwd_*` in the same cycle, with no register.
- Values after reset:
  - All registered outputs are 0.
  - Registered rs1 and rs2 are 0, so `SrcA`=0, `SrcB`=0, `ex_store_data`=0 and `fwd_a`=`fwd_b`=00, whatever the forwarding inputs.
- Reset in the middle of a stall or flush wins on that edge.
- A stall release loads on the first edge where `stall`=0.
- A one-cycle flush produces exactly one bubble cycle (`ex_valid`=0).
- No arithmetic is performed, so no width extension is needed: all data paths are exactly DATA_WIDTH bits.

## Test plan
- Reset then idle:
  - Assert reset for 2 cycles with exmem_rd=0, exmem_reg_write=1 and random results.
  - Required: all outputs 0 and `fwd_a`=`fwd_b`=00.
- Plain capture:
  - Stimulus: id_rs1_data=5, id_rs2_data=7, id_alu_op=0010, alu_src=0, rs1=1, rs2=2, rd=3, with no forwarding matches.
  - Required, next cycle: SrcA=5, SrcB=7, Operation=0010, ex_rd=3, ex_valid=1.
- Double hazard:
  - Stimulus: registered rs1=4, exmem_rd=4 with result 0x11, memwb_rd=4 with result 0x22, both reg_write=1.
  - Required: SrcA=0x11, fwd_a=10.
  - Then drop exmem_reg_write. Required: SrcA=0x22, fwd_a=01.
- Immediate vs store:
  - Stimulus: alu_src=1, imm=0xFFFFFFF0, rs2=6, memwb_rd=6 with result 0x99.
  - Required: SrcB=0xFFFFFFF0, ex_store_data=0x99, fwd_b=01.
- x0 guard:
  - Stimulus: rs1=0, rs1_data=0, exmem_rd=0, exmem_reg_write=1, result 0xDEAD.
  - Required: SrcA=0, fwd_a=00.
- Stall/flush:
  - Stall for 3 cycles while the id inputs change. Required: registered outputs hold.
  - Assert flush and stall together. Required: bubble next cycle (ex_valid=0, ex_reg_write=0, Operation=0000).
